// File: rtl/exmem_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: control-bit layout,
// payload width helper, skid-buffer state encoding and branch decision.
package exmem_pkg;

  localparam int CTRL_W          = 6;
  // Bit positions inside ctrl = {branch, mem_read, mem_to_reg, mem_write, reg_write, jump}
  localparam int CTRL_JUMP       = 0;
  localparam int CTRL_REG_WRITE  = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_BRANCH     = 5;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  // Payload = alu_res, pc_plus4, target, wdata, pc_count, zero, wreg, ctrl
  function automatic int payload_w(input int data_w, input int reg_w);
    return 5 * data_w + 1 + reg_w + CTRL_W;
  endfunction

  localparam int PAYLOAD_W = payload_w(DATA_W_DEF, REG_W_DEF);

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Branch/jump taken decision for a (possibly empty) head entry
  function automatic logic take_branch(input logic vld,
                                       input logic [CTRL_W-1:0] ctrl,
                                       input logic zero);
    return vld & ((ctrl[CTRL_BRANCH] & zero) | ctrl[CTRL_JUMP]);
  endfunction

endpackage

// File: rtl/exmem_if.sv
// One valid/ready beat channel carrying the EX->MEM payload.
interface exmem_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  import exmem_pkg::*;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] pc_count;
  logic              zero;
  logic [REG_W-1:0]  wreg;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid, alu_res, pc_plus4, target, wdata, pc_count, zero, wreg, ctrl,
    input  ready
  );

  modport slave (
    input  valid, alu_res, pc_plus4, target, wdata, pc_count, zero, wreg, ctrl,
    output ready
  );

endinterface

// File: rtl/exmem_pipe_stage_skid.sv
// Generic two-entry skid buffer: registered in_ready, in-order delivery,
// synchronous flush that empties both entries.
module pipe_skid_buf
  import exmem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_p1, skid_p1;
  logic [WIDTH-1:0] head_d, skid_d;
  logic             ready_p1;
  logic             accept, retire;

  assign accept    = in_valid & ready_p1;
  assign retire    = (state_q != SKID_EMPTY) & out_ready;
  assign in_ready  = ready_p1;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = head_p1;

  // Next state and entry loads; flush overrides everything
  always_comb begin
    state_d = state_q;
    head_d  = head_p1;
    skid_d  = skid_p1;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d = SKID_ONE;
          head_d  = in_data;
        end
      end
      SKID_ONE: begin
        if (accept && retire) begin
          head_d = in_data;
        end else if (accept) begin
          state_d = SKID_FULL;
          skid_d  = in_data;
        end else if (retire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only a retire can happen
        if (retire) begin
          state_d = SKID_ONE;
          head_d  = skid_p1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (flush) state_d = SKID_EMPTY;
  end

  // State, registered in_ready and entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SKID_EMPTY;
      ready_p1 <= 1'b1;
      head_p1  <= '0;
      skid_p1  <= '0;
    end else begin
      state_q  <= state_d;
      ready_p1 <= (state_d != SKID_FULL);
      head_p1  <= head_d;
      skid_p1  <= skid_d;
    end
  end

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready, optional skid buffer, flush
// and a branch-resolve output computed from the head entry only.
module exmem_pipe_stage
  import exmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SKID   = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  exmem_if.slave  in_bus,
  exmem_if.master out_bus,
  output logic    out_take_br
);

  localparam int PW = payload_w(DATA_W, REG_W);

  logic [PW-1:0]     in_data;
  logic [PW-1:0]     head_data;
  logic              head_vld;
  logic [CTRL_W-1:0] head_ctrl;

  assign in_data = {in_bus.alu_res, in_bus.pc_plus4, in_bus.target, in_bus.wdata,
                    in_bus.pc_count, in_bus.zero, in_bus.wreg, in_bus.ctrl};

  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_buf #(
        .WIDTH (PW)
      ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_bus.valid),
        .in_ready  (in_bus.ready),
        .in_data   (in_data),
        .out_valid (head_vld),
        .out_ready (out_bus.ready),
        .out_data  (head_data)
      );
    end else begin : g_reg
      logic          vld_p1;
      logic [PW-1:0] data_p1;

      // Single register: free when empty or being drained this cycle
      assign in_bus.ready = out_bus.ready | ~vld_p1;
      assign head_vld     = vld_p1;
      assign head_data    = data_p1;

      // Load on every ready cycle; an idle input leaves a bubble
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else if (flush) begin
          vld_p1 <= 1'b0;
        end else if (in_bus.ready) begin
          vld_p1 <= in_bus.valid;
          if (in_bus.valid) data_p1 <= in_data;
        end
      end
    end
  endgenerate

  // ---- head entry -> MEM stage ----
  assign {out_bus.alu_res, out_bus.pc_plus4, out_bus.target, out_bus.wdata,
          out_bus.pc_count, out_bus.zero, out_bus.wreg, head_ctrl} = head_data;

  assign out_bus.valid = head_vld;
  // A bubble must never carry write enables into MEM
  assign out_bus.ctrl  = head_vld ? head_ctrl : '0;
  assign out_take_br   = take_branch(head_vld, head_ctrl, out_bus.zero);

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Bench for exmem_pipe_stage: one SKID=1 and one SKID=0 instance, queue
// scoreboards per instance, scenario tasks run in sequence.
module tb_exmem_pipe_stage;
  import exmem_pkg::*;

  localparam int PW = PAYLOAD_W;

  logic clk;
  logic rst;
  logic flush1, flush0;
  logic take_br1, take_br0;

  exmem_if #(.DATA_W(32), .REG_W(5)) in1 ();
  exmem_if #(.DATA_W(32), .REG_W(5)) out1 ();
  exmem_if #(.DATA_W(32), .REG_W(5)) in0 ();
  exmem_if #(.DATA_W(32), .REG_W(5)) out0 ();

  exmem_pipe_stage #(.DATA_W(32), .REG_W(5), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_bus(in1), .out_bus(out1), .out_take_br(take_br1)
  );

  exmem_pipe_stage #(.DATA_W(32), .REG_W(5), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_bus(in0), .out_bus(out0), .out_take_br(take_br0)
  );

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] q1[$];
  logic [PW-1:0] q0[$];
  logic [PW-1:0] obs1, obs0;

  assign obs1 = {out1.alu_res, out1.pc_plus4, out1.target, out1.wdata,
                 out1.pc_count, out1.zero, out1.wreg, out1.ctrl};
  assign obs0 = {out0.alu_res, out0.pc_plus4, out0.target, out0.wdata,
                 out0.pc_count, out0.zero, out0.wreg, out0.ctrl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] beat(input int n);
    logic [31:0] v;
    logic [4:0]  r;
    v = n;
    r = v[4:0] + 5'd1;
    return {v, v + 32'd4, v + 32'h1000, ~v, v + 32'd7, v[1], r, v[5:0]};
  endfunction

  task automatic set_in1(input logic vld, input logic [PW-1:0] p);
    in1.valid = vld;
    {in1.alu_res, in1.pc_plus4, in1.target, in1.wdata,
     in1.pc_count, in1.zero, in1.wreg, in1.ctrl} = p;
  endtask

  task automatic set_in0(input logic vld, input logic [PW-1:0] p);
    in0.valid = vld;
    {in0.alu_res, in0.pc_plus4, in0.target, in0.wdata,
     in0.pc_count, in0.zero, in0.wreg, in0.ctrl} = p;
  endtask

  task automatic test_reset();
    checks++;
    if (out1.valid !== 1'b0 || out1.ctrl !== '0 || take_br1 !== 1'b0 || obs1 !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b ctrl=%h take_br=%b payload_alu=%0d, required all 0",
               out1.valid, out1.ctrl, take_br1, out1.alu_res);
    end
    checks++;
    if (in1.ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in1.ready);
    end
    @(negedge clk);
    rst = 1'b0;
    out1.ready = 1'b0;
    set_in1(1'b1, beat(99));
    @(negedge clk);
    set_in1(1'b0, '0);
    checks++;
    if (out1.valid !== 1'b1 || out1.alu_res !== 32'd99) begin
      failures++;
      $display("FAIL reset_preload: valid=%b alu=%0d required 1/99", out1.valid, out1.alu_res);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out1.valid !== 1'b0 || out1.ctrl !== '0 || take_br1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_clear: valid=%b ctrl=%h required 0/0", out1.valid, out1.ctrl);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in1.ready !== 1'b1 || out1.valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in1.ready, out1.valid);
    end
    set_in1(1'b1, beat(5));
    out1.ready = 1'b1;
    @(posedge clk);
    #1;
    set_in1(1'b0, '0);
    @(negedge clk);
    checks++;
    if (out1.valid !== 1'b1 || obs1 !== beat(5)) begin
      failures++;
      $display("FAIL reset_first_accept: valid=%b alu=%0d required 1/5", out1.valid, out1.alu_res);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    logic [PW-1:0] cur;
    out1.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cur = beat(i + 1);
      set_in1(i < 8, cur);
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (in1.ready !== 1'b1) begin
          failures++;
          $display("FAIL stream_in_ready: cycle %0d got %b required 1", i, in1.ready);
        end
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if (out1.valid !== 1'b1 || out1.alu_res !== 32'(i)) begin
          failures++;
          $display("FAIL stream_latency: cycle %0d valid=%b alu=%0d required 1/%0d",
                   i, out1.valid, out1.alu_res, i);
        end
      end
      if (out1.valid && out1.ready && !flush1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL stream_sb: unexpected beat alu=%0d, none expected", out1.alu_res);
        end else begin
          if (obs1 !== q1[0]) begin
            failures++;
            $display("FAIL stream_sb: got alu=%0d required alu=%0d", out1.alu_res, q1[0][PW-1 -: 32]);
          end
          void'(q1.pop_front());
        end
      end
      if (flush1) q1.delete();
      else if (in1.valid && in1.ready) q1.push_back(cur);
      @(posedge clk);
      #1;
    end
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL stream_drain: %0d beats never delivered, required 0", q1.size());
    end
  endtask

  task automatic test_back_pressure();
    logic [PW-1:0] cur, held;
    int n;
    n = 20;
    cur = beat(n);
    held = '0;
    for (int i = 0; i < 18; i++) begin
      out1.ready = !(i >= 3 && i <= 5);
      set_in1(i < 10, cur);
      @(negedge clk);
      if (i == 4 || i == 5) begin
        checks++;
        if (in1.ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready_low: cycle %0d got %b required 0", i, in1.ready);
        end
      end
      if (i == 3) held = obs1;
      if (i == 5) begin
        checks++;
        if (out1.valid !== 1'b1 || obs1 !== held) begin
          failures++;
          $display("FAIL bp_hold_stable: alu=%0d required %0d", out1.alu_res, held[PW-1 -: 32]);
        end
      end
      if (out1.valid && out1.ready && !flush1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL bp_sb: unexpected beat alu=%0d, none expected", out1.alu_res);
        end else begin
          if (obs1 !== q1[0]) begin
            failures++;
            $display("FAIL bp_sb: got alu=%0d required alu=%0d", out1.alu_res, q1[0][PW-1 -: 32]);
          end
          void'(q1.pop_front());
        end
      end
      if (flush1) q1.delete();
      else if (in1.valid && in1.ready) begin
        q1.push_back(cur);
        n++;
        cur = beat(n);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (q1.size() != 0 || n != 27) begin
      failures++;
      $display("FAIL bp_no_loss: pending=%0d accepted_to=%0d required 0/27", q1.size(), n);
    end
  endtask

  task automatic test_flush();
    logic [PW-1:0] cur;
    int n;
    n = 40;
    cur = beat(n);
    for (int i = 0; i < 13; i++) begin
      out1.ready = (i >= 5);
      flush1     = (i == 2 || i == 4);
      set_in1(i < 9, cur);
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (in1.ready !== 1'b0 || out1.valid !== 1'b1) begin
          failures++;
          $display("FAIL flush_full_state: in_ready=%b out_valid=%b required 0/1", in1.ready, out1.valid);
        end
      end
      if (i == 3 || i == 5) begin
        checks++;
        if (out1.valid !== 1'b0 || out1.ctrl !== '0 || take_br1 !== 1'b0 || in1.ready !== 1'b1) begin
          failures++;
          $display("FAIL flush_clear: cycle %0d valid=%b ctrl=%h in_ready=%b required 0/0/1",
                   i, out1.valid, out1.ctrl, in1.ready);
        end
      end
      if (out1.valid && out1.ready && !flush1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL flush_sb: unexpected beat alu=%0d, none expected", out1.alu_res);
        end else begin
          if (obs1 !== q1[0]) begin
            failures++;
            $display("FAIL flush_sb: got alu=%0d required alu=%0d", out1.alu_res, q1[0][PW-1 -: 32]);
          end
          void'(q1.pop_front());
        end
      end
      if (flush1) begin
        q1.delete();
        n++;
        cur = beat(n);
      end else if (in1.valid && in1.ready) begin
        q1.push_back(cur);
        n++;
        cur = beat(n);
      end
      @(posedge clk);
      #1;
    end
    flush1 = 1'b0;
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL flush_drain: %0d beats never delivered, required 0", q1.size());
    end
  endtask

  task automatic test_branch();
    logic [PW-1:0]     p;
    logic [CTRL_W-1:0] c;
    logic [3:0]        tbl [5];
    // {branch, jump, zero, expected take_br}
    tbl[0] = 4'b1011;
    tbl[1] = 4'b1000;
    tbl[2] = 4'b0101;
    tbl[3] = 4'b0111;
    tbl[4] = 4'b0010;
    out1.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c = '0;
      c[CTRL_BRANCH]     = tbl[k][3];
      c[CTRL_JUMP]       = tbl[k][2];
      c[CTRL_MEM_READ]   = 1'b1;
      c[CTRL_MEM_TO_REG] = k[0];
      c[CTRL_REG_WRITE]  = k[1];
      c[CTRL_MEM_WRITE]  = 1'b0;
      p = beat(60 + k);
      p[CTRL_W-1:0]      = c;
      p[CTRL_W + 5]      = tbl[k][1];
      set_in1(1'b1, p);
      @(posedge clk);
      #1;
      set_in1(1'b0, '0);
      @(negedge clk);
      checks++;
      if (take_br1 !== tbl[k][0] || out1.ctrl !== c || out1.valid !== 1'b1) begin
        failures++;
        $display("FAIL branch_case%0d: take_br=%b ctrl=%h valid=%b required %b/%h/1",
                 k, take_br1, out1.ctrl, out1.valid, tbl[k][0], c);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (out1.valid !== 1'b0 || take_br1 !== 1'b0) begin
      failures++;
      $display("FAIL branch_bubble: valid=%b take_br=%b required 0/0", out1.valid, take_br1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [PW-1:0] cur1, cur0;
    logic          pend1, pend0, v1, v0;
    int            n1, n0;
    n1 = 100;  n0 = 1000;
    cur1 = beat(n1);  cur0 = beat(n0);
    pend1 = 1'b0;  pend0 = 1'b0;
    v1 = 1'b0;  v0 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i >= 980) begin
        v1 = 1'b0;  v0 = 1'b0;
        out1.ready = 1'b1;  out0.ready = 1'b1;
      end else begin
        if (!pend1) v1 = ($urandom_range(0, 3) != 0);
        if (!pend0) v0 = ($urandom_range(0, 1) != 0);
        out1.ready = ($urandom_range(0, 2) != 0);
        out0.ready = ($urandom_range(0, 1) != 0);
      end
      set_in1(v1, cur1);
      set_in0(v0, cur0);
      @(negedge clk);
      checks++;
      if (in0.ready !== (out0.ready | ~out0.valid)) begin
        failures++;
        $display("FAIL rand_skid0_ready: cycle %0d got %b required %b",
                 i, in0.ready, out0.ready | ~out0.valid);
      end
      if (!out0.valid) begin
        checks++;
        if (out0.ctrl !== '0 || take_br0 !== 1'b0) begin
          failures++;
          $display("FAIL rand_skid0_bubble: cycle %0d ctrl=%h take_br=%b required 0", i, out0.ctrl, take_br0);
        end
      end
      if (!out1.valid) begin
        checks++;
        if (out1.ctrl !== '0 || take_br1 !== 1'b0) begin
          failures++;
          $display("FAIL rand_skid1_bubble: cycle %0d ctrl=%h take_br=%b required 0", i, out1.ctrl, take_br1);
        end
      end
      if (out1.valid && out1.ready) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL rand_skid1_sb: unexpected beat alu=%0d, none expected", out1.alu_res);
        end else begin
          if (obs1 !== q1[0]) begin
            failures++;
            $display("FAIL rand_skid1_sb: got alu=%0d required alu=%0d", out1.alu_res, q1[0][PW-1 -: 32]);
          end
          void'(q1.pop_front());
        end
      end
      if (out0.valid && out0.ready) begin
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL rand_skid0_sb: unexpected beat alu=%0d, none expected", out0.alu_res);
        end else begin
          if (obs0 !== q0[0]) begin
            failures++;
            $display("FAIL rand_skid0_sb: got alu=%0d required alu=%0d", out0.alu_res, q0[0][PW-1 -: 32]);
          end
          void'(q0.pop_front());
        end
      end
      pend1 = in1.valid & ~in1.ready;
      pend0 = in0.valid & ~in0.ready;
      if (in1.valid && in1.ready) begin
        q1.push_back(cur1);
        n1++;
        cur1 = beat(n1);
      end
      if (in0.valid && in0.ready) begin
        q0.push_back(cur0);
        n0++;
        cur0 = beat(n0);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      failures++;
      $display("FAIL rand_drain: pending skid1=%0d skid0=%0d required 0/0", q1.size(), q0.size());
    end
  endtask

  initial begin
    rst    = 1'b1;
    flush1 = 1'b0;
    flush0 = 1'b0;
    set_in1(1'b0, '0);
    set_in0(1'b0, '0);
    out1.ready = 1'b0;
    out0.ready = 1'b0;
    #3;
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_branch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
